// File: rtl/banner_pkg.sv
// banner_pkg
// Shared definitions for the banner flow-control slice: scheduler state
// encoding, the default coordinate counter width and the width of the
// optional stall statistics counter (BANNER_FLOW_STAT_EN builds only).
package banner_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int STAT_W    = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/banner_xy_counter.sv
// banner_xy_counter
// Raster x/y counter for one frame. load latches the frame size as
// terminal values (width-1, height-1) and restarts at (0,0); each inc
// advances one pixel in raster order.
// Ports:
//   clk, reset      clock and synchronous active-low reset
//   load            latch width/height and restart at (0,0)
//   width, height   frame size, sampled only while load is high
//   inc             advance one pixel
//   x, y            coordinate of the next pixel to be issued
//   first, last     next pixel is the first / last of the frame
module banner_xy_counter
  import banner_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] width,
  input  logic [CNT_W-1:0] height,
  input  logic             inc,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             first,
  output logic             last
);

  logic [CNT_W-1:0] w_m1;
  logic [CNT_W-1:0] h_m1;

  // Terminal values are computed once per frame, so the per-pixel compare
  // is a plain equality and the counters can never run past the frame.
  always_ff @(posedge clk) begin
    if (load) begin
      w_m1 <= width - 1'b1;
      h_m1 <= height - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      x <= '0;
      y <= '0;
    end else if (load) begin
      x <= '0;
      y <= '0;
    end else if (inc) begin
      if (x == w_m1) begin
        x <= '0;
        y <= (y == h_m1) ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  assign first = (x == '0) && (y == '0);
  assign last  = (x == w_m1) && (y == h_m1);

endmodule

// File: rtl/symbol_delay_data.sv
// symbol_delay_data
// Fixed-depth shift register delay line. Every stage shifts on every clock;
// there is no enable, so the output is exactly din delayed N cycles.
// Ports:
//   clk    system clock
//   reset  synchronous active-low reset, clears every stage
//   din    DATA_W-bit input word
//   dout   DATA_W-bit word delayed by N cycles
module symbol_delay_data #(
  parameter int N      = 1,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] pipe_p [N];

  // Stage p0 captures din; stage pN-1 drives dout.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) pipe_p[i] <= '0;
    end else begin
      pipe_p[0] <= din;
      for (int i = 1; i < N; i++) pipe_p[i] <= pipe_p[i-1];
    end
  end

  assign dout = pipe_p[N-1];

endmodule

// File: rtl/banner_flow_ctrl.sv
// banner_flow_ctrl
// Frame-level read scheduler between the 24-bit sink FIFO and the
// data/mask source FIFO pair. Reads are issued only while the sink has a
// word and both source FIFOs have room; every read is echoed RD_LAT cycles
// later as a write strobe with its pixel coordinate and frame markers.
// Optional build macro: BANNER_FLOW_STAT_EN adds the 32-bit stall_cnt port.
// Ports:
//   clk, reset                 clock, synchronous active-low reset
//   WIDTH, HEIGHT, size_valid  next frame size and its level-valid flag
//   enable                     scheduler enable (honoured between frames)
//   din_almost_empty           sink FIFO cannot supply a word
//   dout_almost_full_data/mask source FIFOs near full
//   dout_rdreq                 read strobe to the sink FIFO
//   data_valid_out             write strobe to the source FIFOs
//   x_out, y_out               coordinate qualified by data_valid_out
//   sof_out, eof_out           first / last pixel of the frame
//   busy                       scheduler is not idle
//   size_err                   sticky: a zero WIDTH or HEIGHT was loaded
//   stall_cnt                  (BANNER_FLOW_STAT_EN) stalled RUN cycles
module banner_flow_ctrl
  import banner_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] WIDTH,
  input  logic [CNT_W-1:0] HEIGHT,
  input  logic             size_valid,
  input  logic             enable,
  input  logic             din_almost_empty,
  input  logic             dout_almost_full_data,
  input  logic             dout_almost_full_mask,
  output logic             dout_rdreq,
  output logic             data_valid_out,
  output logic [CNT_W-1:0] x_out,
  output logic [CNT_W-1:0] y_out,
  output logic             sof_out,
  output logic             eof_out,
  output logic             busy,
  output logic             size_err
`ifdef BANNER_FLOW_STAT_EN
  ,
  output logic [STAT_W-1:0] stall_cnt
`endif
);

  localparam int DL_W = 3 + 2 * CNT_W;

  state_t           state;
  logic [2:0]       drain_cnt;
  logic             flow_ok;
  logic [CNT_W-1:0] x_cur;
  logic [CNT_W-1:0] y_cur;
  logic             first_cur;
  logic             last_cur;
  logic [DL_W-1:0]  dl_in;
  logic [DL_W-1:0]  dl_out;

  // The read strobe must react in the same cycle the FIFO flags clear, so
  // it is gated combinationally from the registered state.
  assign flow_ok    = !din_almost_empty && !dout_almost_full_data && !dout_almost_full_mask;
  assign dout_rdreq = (state == ST_RUN) && flow_ok;
  assign busy       = (state != ST_IDLE);

  banner_xy_counter #(
    .CNT_W (CNT_W)
  ) u_xy (
    .clk    (clk),
    .reset  (reset),
    .load   (state == ST_LOAD),
    .width  (WIDTH),
    .height (HEIGHT),
    .inc    (dout_rdreq),
    .x      (x_cur),
    .y      (y_cur),
    .first  (first_cur),
    .last   (last_cur)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      size_err  <= 1'b0;
      drain_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enable && size_valid) state <= ST_LOAD;
        end
        ST_LOAD: begin
          if ((WIDTH == '0) || (HEIGHT == '0)) begin
            size_err <= 1'b1;
            state    <= ST_IDLE;
          end else begin
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (dout_rdreq && last_cur) begin
            state     <= ST_DRAIN;
            drain_cnt <= '0;
          end
        end
        ST_DRAIN: begin
          // The last read leaves the delay line on the final DRAIN cycle.
          if (drain_cnt == 3'(RD_LAT - 1)) begin
            state <= (enable && size_valid) ? ST_LOAD : ST_IDLE;
          end else begin
            drain_cnt <= drain_cnt + 3'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Pixel payload is zeroed on idle cycles so markers never appear
  // without the strobe.
  assign dl_in = {dout_rdreq,
                  dout_rdreq ? x_cur : '0,
                  dout_rdreq ? y_cur : '0,
                  dout_rdreq && first_cur,
                  dout_rdreq && last_cur};

  symbol_delay_data #(
    .N      (RD_LAT),
    .DATA_W (DL_W)
  ) u_delay (
    .clk   (clk),
    .reset (reset),
    .din   (dl_in),
    .dout  (dl_out)
  );

  assign {data_valid_out, x_out, y_out, sof_out, eof_out} = dl_out;

`ifdef BANNER_FLOW_STAT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (state == ST_LOAD) begin
      stall_cnt <= '0;
    end else if ((state == ST_RUN) && !dout_rdreq && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule
